// File: rtl/smvm_row_packer_if.sv
// Element-stream and packet handshake bundle for smvm_row_packer.
// master drives elements and pkt_ready; slave is the packer.
interface smvm_row_packer_if #(
    parameter int K     = 4,
    parameter int COL_W = 7
);
    logic                       in_valid;
    logic                       in_ready;
    logic [7:0]                 val_in;
    logic [COL_W-1:0]           col_in;
    logic                       ipv_in;
    logic                       last_in;
    logic                       pkt_valid;
    logic                       pkt_ready;
    logic [8*K-1:0]             pkt_val;
    logic [COL_W*K-1:0]         pkt_col;
    logic [K-1:0]               pkt_ipv;
    logic [K-1:0]               pkt_mask;
    logic [$clog2(K+1)-1:0]     pkt_rows;
    logic                       pkt_last;

    modport master (
        output in_valid, val_in, col_in, ipv_in, last_in, pkt_ready,
        input  in_ready, pkt_valid, pkt_val, pkt_col, pkt_ipv,
        input  pkt_mask, pkt_rows, pkt_last
    );

    modport slave (
        input  in_valid, val_in, col_in, ipv_in, last_in, pkt_ready,
        output in_ready, pkt_valid, pkt_val, pkt_col, pkt_ipv,
        output pkt_mask, pkt_rows, pkt_last
    );
endinterface

// File: rtl/smvm_row_packer.sv
// Packs serial (value, column, IPV) elements into K-lane packets.
// Assembly register feeds a one-deep output register; lane 0 sits in the MSBs.
module smvm_row_packer #(
    parameter int K     = 4,
    parameter int COL_W = 7
) (
    input logic             clk,
    input logic             rst,
    smvm_row_packer_if.slave bus
);
    localparam int LW = $clog2(K);
    localparam int RW = $clog2(K + 1);

    typedef enum logic {ASM, HOLD} state_t;

    state_t                   state, state_nx;
    logic [LW-1:0]            lane_cnt;
    logic [LW-1:0]            idx;
    logic [K-1:0][7:0]        a_val, m_val, o_val;
    logic [K-1:0][COL_W-1:0]  a_col, m_col, o_col;
    logic [K-1:0]             a_ipv, m_ipv, o_ipv;
    logic [K-1:0]             a_mask, m_mask, o_mask;
    logic                     a_last, m_last, o_last;
    logic                     o_valid;
    logic [RW-1:0]            rows;
    logic                     acc, consume, out_free, closing;
    logic                     xfer, asm_wr;

    assign bus.in_ready = (state == ASM);
    assign acc          = bus.in_valid & bus.in_ready;
    assign consume      = o_valid & bus.pkt_ready;
    assign out_free     = ~o_valid | bus.pkt_ready;
    assign closing      = acc & ((lane_cnt == LW'(K - 1)) | bus.last_in);
    assign idx          = LW'(K - 1) - lane_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ASM;
        else     state <= state_nx;
    end

    // Next state: transfer on closure when output frees, else park in HOLD
    always_comb begin
        state_nx = state;
        xfer     = 1'b0;
        asm_wr   = 1'b0;
        unique case (state)
            ASM: begin
                if (closing) begin
                    if (out_free) begin
                        xfer = 1'b1;
                    end else begin
                        asm_wr   = 1'b1;
                        state_nx = HOLD;
                    end
                end else if (acc) begin
                    asm_wr = 1'b1;
                end
            end
            HOLD: begin
                if (consume) begin
                    xfer     = 1'b1;
                    state_nx = ASM;
                end
            end
            default: state_nx = ASM;
        endcase
    end

    // Assembly contents with this cycle's element merged into its lane
    always_comb begin
        m_val  = a_val;
        m_col  = a_col;
        m_ipv  = a_ipv;
        m_mask = a_mask;
        m_last = a_last;
        if (acc) begin
            m_val[idx]  = bus.val_in;
            m_col[idx]  = bus.col_in;
            m_ipv[idx]  = bus.ipv_in;
            m_mask[idx] = 1'b1;
            m_last      = a_last | bus.last_in;
        end
    end

    // Assembly register: cleared on transfer, extended on accept
    always_ff @(posedge clk) begin
        if (rst || xfer) begin
            a_val    <= '0;
            a_col    <= '0;
            a_ipv    <= '0;
            a_mask   <= '0;
            a_last   <= 1'b0;
            lane_cnt <= '0;
        end else if (asm_wr) begin
            a_val    <= m_val;
            a_col    <= m_col;
            a_ipv    <= m_ipv;
            a_mask   <= m_mask;
            a_last   <= m_last;
            lane_cnt <= closing ? '0 : lane_cnt + 1'b1;
        end
    end

    // Output register: loads on transfer, drops valid on bare consume
    always_ff @(posedge clk) begin
        if (rst) begin
            o_val   <= '0;
            o_col   <= '0;
            o_ipv   <= '0;
            o_mask  <= '0;
            o_last  <= 1'b0;
            o_valid <= 1'b0;
        end else if (xfer) begin
            o_val   <= m_val;
            o_col   <= m_col;
            o_ipv   <= m_ipv;
            o_mask  <= m_mask;
            o_last  <= m_last;
            o_valid <= 1'b1;
        end else if (consume) begin
            o_valid <= 1'b0;
        end
    end

    // Row count is the number of row starts in the visible packet
    always_comb begin
        rows = '0;
        for (int i = 0; i < K; i++) rows = rows + RW'(o_ipv[i]);
    end

    assign bus.pkt_valid = o_valid;
    assign bus.pkt_val   = o_val;
    assign bus.pkt_col   = o_col;
    assign bus.pkt_ipv   = o_ipv;
    assign bus.pkt_mask  = o_mask;
    assign bus.pkt_last  = o_last;
    assign bus.pkt_rows  = rows;
endmodule

// File: doc/smvm_row_packer.md
# smvm_row_packer

Upstream input stage of the SMVM datapath. Accepts the serial stream of nonzero matrix elements as (value, column index, IPV) triples, one per cycle, and groups them into K-lane packets for the L1 multiplier array and the IPV reducer. Elastic on both sides: valid/ready in, valid/ready out. A two-register scheme (assembly register plus output register) sustains one element per cycle when downstream is always ready.

## Interface
- K, 4: lanes per packet. Must be ≥2.
- COL_W, 7: column-index width, supports up to 128 vector entries.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  element present on val_in/col_in/ipv_in/last_in.
- in_ready  out  1  block accepts the element this cycle.
- val_in  in  8  signed matrix value.
- col_in  in  COL_W  column index of the value.
- ipv_in  in  1  1 = element is the first nonzero of a new row.
- last_in  in  1  final element of the matrix; forces packet flush.
- pkt_valid  out  1  output packet present.
- pkt_ready  in  1  downstream consumes the packet this cycle.
- pkt_val  out  8*K  lane values. Lane l is at [8*(K-l)-1 : 8*(K-l-1)], so lane 0 is in the MSBs.
- pkt_col  out  COL_W*K  lane column indices, same lane ordering.
- pkt_ipv  out  K  per-lane IPV, bit K-1-l = lane l.
- pkt_mask  out  K  lane-occupied mask, bit K-1-l = lane l.
- pkt_rows  out  $clog2(K+1)  popcount of pkt_ipv.
- pkt_last  out  1  packet contains the last_in element.

## Operation
- Input handshake: an element is accepted when in_valid & in_ready.
- Output handshake: a packet is consumed when pkt_valid & pkt_ready.
- Assembly register: lanes fill in order 0..K-1, tracked by lane_cnt (0..K-1).
  - An accepted element writes lane lane_cnt, sets its mask bit, and copies ipv_in.
- Packet closure: the packet closes when it fills lane K-1 or accepts an element with last_in=1.
  - Unfilled lanes read as val=0, col=0, ipv=0, mask=0.
  - last_in also sets the packet's last flag.
- FSM states:
  - ASM: in_ready=1.
    - On closure, if the output register is empty or being consumed this cycle, transfer the packet, clear the assembly register, reset lane_cnt to 0, and stay in ASM.
    - Otherwise hold the closed packet and go to HOLD.
  - HOLD: in_ready=0.
    - When the output register is consumed, transfer the held packet, clear the assembly register, and return to ASM.
- Output register: loaded only on transfer. pkt_valid is set on load and cleared on consume without a simultaneous load.
  - Contents are stable while pkt_valid=1 and pkt_ready=0.
- pkt_rows is computed combinationally from the output register's pkt_ipv.
- last_in=1 with in_valid=0 is ignored. Flush requires an accepted element.
- After a pkt_last packet is consumed, the block is idle and ready for the next matrix with no reset needed.
- Reset, including mid-packet: state=ASM, lane_cnt=0, assembly and output registers cleared, pkt_valid=0. Any partial packet is discarded.

## Timing
- Reset values: in_ready=1, pkt_valid=0, and pkt_val, pkt_col, pkt_ipv, pkt_mask, pkt_rows, pkt_last all 0.
- Latency: the closing element accepted at edge t appears with pkt_valid=1 in the cycle after edge t (one register stage).
- Throughput: with pkt_ready held at 1, in_ready never drops; one full packet every K cycles.
- Simultaneous closure and consume in the same cycle: the new packet replaces the consumed one with no bubble, and pkt_valid stays 1.
- Backpressure: at most K elements are accepted beyond the held output packet, then in_ready=0.
  - in_ready returns to 1 the cycle after the consume that frees HOLD.
- in_ready depends only on registered state, with no combinational path from pkt_ready to in_ready.

## Test plan
- Reset, then 4 elements (10,c3,ipv1), (-5,c0,0), (7,c1,1), (2,c6,0) with pkt_ready=1 → one cycle after the 4th: pkt_val=0x0AFB0702, pkt_mask=4'b1111, pkt_ipv=4'b1010, pkt_rows=2, pkt_last=0; in_ready stays 1 throughout.
- 6 elements with last_in on the 6th → first packet mask 1111; second packet holds lanes 0-1, mask=1100, lanes 2-3 val=0, pkt_last=1.
- pkt_ready=0, stream 12 elements → first packet held stable; in_ready falls after the 8th acceptance. Raise pkt_ready: the second packet appears and in_ready=1 again. No element is lost or duplicated.
- Single element (-128,c127,ipv1,last) → pkt_val=0x80000000, pkt_col lane 0=127, mask=1000, rows=1, last=1.
- Assert rst after 2 elements accepted, with one packet pending unconsumed → next cycle pkt_valid=0, in_ready=1. The following 4 elements form a clean packet with no stale lanes.
- Random stream of 1000 elements with random in_valid/pkt_ready, checked against a scoreboard model: lane order, masks, row counts and last flags all match.
